// File: rtl/ndrot_drv_pkg.sv
// Shared types and defaults for the NDRO-T cell driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: command opcode enum, FSM state enum, default timing constants.
package ndrot_drv_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_SET   = 2'b01,
      OP_RESET = 2'b10,
      OP_READ  = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GUARD  = 2'b01,
      ST_WAIT_Q = 2'b10,
      ST_RESP   = 2'b11
   } state_e;

   localparam int GAP_AB_DEF    = 2;
   localparam int READ_WAIT_DEF = 4;

   // Wide enough for any sensible guard/listen window.
   localparam int CNT_W = 8;

endpackage

// File: rtl/sfq_toggle_sync.sv
// Synchronizes the toggle-encoded q_i line and flags each edge (one SFQ pulse).
// Latency: q_edge is high in the cycle after the first stage captures a new q_i level.
// Backpressure: none; every edge is reported for exactly one cycle.
// Ports: clk, rst_n (async active-low), q_i (asynchronous toggle line), q_edge (one-cycle pulse).
module sfq_toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic q_i,
   output logic q_edge
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], q_i};
      end
   end

   // Any change between the last two stages is one pulse on the cell output.
   assign q_edge = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/ndrot_driver.sv
// Drives an NDRO-T cell through toggle-encoded set/reset/readout lines and collects read results.
// Latency: line edge 1 cycle after accept; write ready again GAP_AB cycles later; read result READ_WAIT+2 cycles after accept.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are ignored, never queued.
// Ports: clk, rst_n; cmd_valid/cmd_ready/cmd_op command handshake; a_o, b_o, clkp_o toggle outputs;
//        q_i toggle input; rsp_valid/rsp_data read strobe; mismatch_o, err_o sticky flags.
module ndrot_driver
   import ndrot_drv_pkg::*;
#(
   parameter int GAP_AB      = GAP_AB_DEF,    // must be >= 1
   parameter int READ_WAIT   = READ_WAIT_DEF, // must be >= 2
   parameter int SYNC_STAGES = 2              // must be >= 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   output logic       a_o,
   output logic       b_o,
   output logic       clkp_o,
   input  logic       q_i,
   output logic       rsp_valid,
   output logic       rsp_data,
   output logic       mismatch_o,
   output logic       err_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_pend_q, rd_pend_d;
   logic             alive_q;
   logic             shadow_q;
   logic             result_q;
   logic             q_edge;
   logic             accept;
   cmd_op_e          op;

   sfq_toggle_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .q_i    (q_i),
      .q_edge (q_edge)
   );

   assign op = cmd_op_e'(cmd_op);

   // alive_q keeps cmd_ready low during reset and rises on the first edge after release.
   assign cmd_ready = alive_q && (state_q == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   // GUARD covers both the write gap (GAP_AB cycles) and the single cycle after a
   // readout edge, before the listen window opens.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_pend_d = rd_pend_q;
      rsp_valid = 1'b0;
      rsp_data  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  OP_SET, OP_RESET: begin
                     state_d   = ST_GUARD;
                     cnt_d     = CNT_W'(GAP_AB - 1);
                     rd_pend_d = 1'b0;
                  end
                  OP_READ: begin
                     state_d   = ST_GUARD;
                     cnt_d     = '0;
                     rd_pend_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_GUARD: begin
            if (cnt_q == '0) begin
               if (rd_pend_q) begin
                  state_d   = ST_WAIT_Q;
                  cnt_d     = CNT_W'(READ_WAIT - 1);
                  rd_pend_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT_Q: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = result_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive_q    <= 1'b0;
         a_o        <= 1'b0;
         b_o        <= 1'b0;
         clkp_o     <= 1'b0;
         shadow_q   <= 1'b0;
         result_q   <= 1'b0;
         mismatch_o <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         // Only one command is accepted per cycle, so at most one line toggles.
         if (accept) begin
            case (op)
               OP_SET: begin
                  a_o      <= ~a_o;
                  shadow_q <= 1'b1;
               end
               OP_RESET: begin
                  b_o      <= ~b_o;
                  shadow_q <= 1'b0;
               end
               OP_READ: begin
                  clkp_o   <= ~clkp_o;
                  result_q <= 1'b0;
               end
               default: ;
            endcase
         end
         if (q_edge) begin
            if (state_q == ST_WAIT_Q) begin
               result_q <= 1'b1;
            end else begin
               err_o <= 1'b1;
            end
         end
         if ((state_q == ST_RESP) && (result_q != shadow_q)) begin
            mismatch_o <= 1'b1;
         end
      end
   end

endmodule

// File: doc/ndrot_driver.md
NDROT_DRIVER -- requirements
Module: ndrot_driver

Interface
REQ-001 Parameter GAP_AB, default 2: minimum clk cycles from an a/b toggle edge to the next command edge.
REQ-002 Parameter READ_WAIT, default 4: cycles the block listens for a q edge after a read edge (SHALL be at least 2).
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on q_i.
REQ-004 clk  input  1  sole clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  block accepts a command this cycle.
REQ-008 cmd_op  input  2  00 NOP, 01 SET, 10 RESET, 11 READ.
REQ-009 a_o  output  1  toggle-encoded set line; each edge is one SFQ pulse.
REQ-010 b_o  output  1  toggle-encoded reset line.
REQ-011 clkp_o  output  1  toggle-encoded readout-clock line to the cell.
REQ-012 q_i  input  1  toggle-encoded cell output; each edge is one pulse.
REQ-013 rsp_valid  output  1  one-cycle read-result strobe.
REQ-014 rsp_data  output  1  1 if a q pulse arrived in the read window.
REQ-015 mismatch_o  output  1  sticky: read result differed from the shadow state.
REQ-016 err_o  output  1  sticky: q pulse outside any read window.

Function
REQ-017 FSM states IDLE, GUARD, WAIT_Q, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-018 A command is accepted in cycle N when cmd_valid and cmd_ready are both 1; cmd_valid in non-IDLE cycles SHALL be ignored and not queued.
REQ-019 SET: a_o SHALL toggle at N+1; shadow SHALL become 1; FSM SHALL go to GUARD and cmd_ready SHALL return at N+1+GAP_AB.
REQ-020 RESET: same timing as SET, on b_o; shadow SHALL become 0.
REQ-021 SET while shadow=1 and RESET while shadow=0 SHALL still emit the edge.
REQ-022 NOP: no line SHALL toggle; cmd_ready SHALL return at N+1.
REQ-023 READ: clkp_o SHALL toggle at N+1; FSM SHALL be in WAIT_Q for cycles N+2 .. N+1+READ_WAIT.
REQ-024 Any synchronized q edge seen in WAIT_Q SHALL set the read result to 1; more than one edge SHALL still give 1.
REQ-025 rsp_valid SHALL be 1 for exactly cycle N+2+READ_WAIT (RESP); rsp_data SHALL hold the result then, and 0 in all other cycles.
REQ-026 In RESP, mismatch_o SHALL be set if rsp_data differs from shadow; shadow SHALL NOT change on READ.
REQ-027 cmd_ready SHALL return the cycle after RESP.
REQ-028 q edge detection: XOR of the last two synchronizer stages.
REQ-029 A q edge detected in IDLE, GUARD or RESP SHALL set err_o and SHALL NOT affect rsp_data.
REQ-030 At most one of a_o, b_o and clkp_o SHALL toggle in any cycle.
REQ-031 Toggle lines SHALL change only as REQ-019/020/023 specify.

Reset
REQ-032 While rst_n=0: a_o, b_o, clkp_o, rsp_valid, rsp_data, mismatch_o, err_o, cmd_ready, shadow and synchronizer flops SHALL be 0; FSM SHALL be IDLE.
REQ-033 cmd_ready SHALL be 1 in the first rising edge after rst_n deasserts.
REQ-034 Reset mid-operation SHALL abort the command with no response. A toggle line at 1 then returns to 0, giving one edge; resetting the cell with it is the integrator's duty.

Structure
REQ-035 Package ndrot_drv_pkg SHALL hold the cmd_op enum, the FSM state enum and the default GAP_AB/READ_WAIT constants.
REQ-036 Sub-module sfq_toggle_sync SHALL implement the q_i synchronizer and edge detector (parameter SYNC_STAGES).

Verification
REQ-037 Reset, SET at N=10 -> a_o 0->1 at 11, cmd_ready 0 in 11-12, 1 at 13.
REQ-038 SET, then READ with q_i toggled 3 cycles after the clkp_o edge -> rsp_valid one cycle, rsp_data=1, mismatch_o=0.
REQ-039 RESET then READ, q_i silent -> rsp_data=0, mismatch_o=0; then READ with q toggle injected -> rsp_data=1, mismatch_o=1 and sticky.
REQ-040 q_i toggled while IDLE -> err_o=1, rsp_valid stays 0.
REQ-041 cmd_valid held high with ops SET, READ, RESET back-to-back -> exactly 3 acceptances and no two line toggles in one cycle.
REQ-042 rst_n pulled low during WAIT_Q -> all outputs 0 immediately, no rsp_valid, cmd_ready=1 one cycle after release.
